shift_register_universal: RTL and testbench

Parametrised universal shift register, successor of the 4-bit bidirectional shift register. It adds generic width, parallel load, rotate, clock enable, serial outputs and a multi-step burst engine with a BUSY/DONE handshake. It sits between serial/parallel data sources and downstream logic that needs shifted, rotated or realigned words.

---
 rtl/shift_register_universal.sv | 130 +++++++++++++
 tb/tb_shift_register_universal.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/shift_register_universal.sv
// Universal shift register: hold/shift/rotate/load with a single-step mode and
// a multi-step burst engine that reports progress through BUSY and a DONE pulse.
module shift_register_universal #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             H,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             SENS,
    input  logic             SR,
    input  logic             SL,
    input  logic [WIDTH-1:0] D,
    input  logic             START,
    input  logic [AMT_W-1:0] AMOUNT,
    output logic [WIDTH-1:0] Q,
    output logic             SO_R,
    output logic             SO_L,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_LOAD   = 2'b11;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [AMT_W-1:0] cnt_reg, cnt_next;
    logic             rot_reg, rot_next;
    logic             left_reg, left_next;
    logic             done_reg, done_next;

    // Inside a burst the latched operation drives the datapath, otherwise the live inputs do.
    logic             step_rot, step_left;
    logic             fill_r, fill_l;
    logic [WIDTH-1:0] shr, shl, stepped;

    always_comb begin
        step_rot  = (state_reg == RUN) ? rot_reg  : (MODE == MODE_ROTATE);
        step_left = (state_reg == RUN) ? left_reg : SENS;
        fill_r    = step_rot ? q_reg[0]       : SR;
        fill_l    = step_rot ? q_reg[WIDTH-1] : SL;
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
        if (gi == WIDTH - 1) begin : g_top
            assign shr[gi] = fill_r;
        end else begin : g_mid_r
            assign shr[gi] = q_reg[gi+1];
        end
        if (gi == 0) begin : g_bot
            assign shl[gi] = fill_l;
        end else begin : g_mid_l
            assign shl[gi] = q_reg[gi-1];
        end
    end

    assign stepped = step_left ? shl : shr;

    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        cnt_next   = cnt_reg;
        rot_next   = rot_reg;
        left_next  = left_reg;
        done_next  = 1'b0;
        if (EN) begin
            case (state_reg)
                IDLE: begin
                    if (START && (MODE == MODE_SHIFT || MODE == MODE_ROTATE)) begin
                        // A zero-length burst completes immediately without entering RUN.
                        if (AMOUNT != '0) begin
                            state_next = RUN;
                            cnt_next   = AMOUNT;
                            rot_next   = MODE[1];
                            left_next  = SENS;
                        end else begin
                            done_next = 1'b1;
                        end
                    end else begin
                        case (MODE)
                            MODE_HOLD:   q_next = q_reg;
                            MODE_LOAD:   q_next = D;
                            default:     q_next = stepped;
                        endcase
                    end
                end
                RUN: begin
                    q_next   = stepped;
                    cnt_next = cnt_reg - AMT_W'(1);
                    if (cnt_reg == AMT_W'(1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge H) begin
        if (RST) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            cnt_reg   <= '0;
            rot_reg   <= 1'b0;
            left_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            cnt_reg   <= cnt_next;
            rot_reg   <= rot_next;
            left_reg  <= left_next;
            done_reg  <= done_next;
        end
    end

    assign Q    = q_reg;
    assign SO_R = q_reg[0];
    assign SO_L = q_reg[WIDTH-1];
    assign BUSY = (state_reg == RUN);
    assign DONE = done_reg;

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed bench for shift_register_universal: a vector table applied edge by
// edge, followed by long bursts that exercise AMOUNT beyond WIDTH.
module tb_shift_register_universal;

    logic       H = 1'b0;
    logic       RST, EN, SENS, SR, SL, START;
    logic [1:0] MODE;
    logic [7:0] D;
    logic [3:0] AMOUNT;
    logic [7:0] Q;
    logic       SO_R, SO_L, BUSY, DONE;

    int checks = 0;
    int errors = 0;

    shift_register_universal #(.WIDTH(8), .AMT_W(4)) dut (
        .H(H), .RST(RST), .EN(EN), .MODE(MODE), .SENS(SENS), .SR(SR), .SL(SL),
        .D(D), .START(START), .AMOUNT(AMOUNT), .Q(Q), .SO_R(SO_R), .SO_L(SO_L),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 H = ~H;

    typedef struct {
        logic       rst, en;
        logic [1:0] mode;
        logic       sens, sr, sl;
        logic [7:0] d;
        logic       start;
        logic [3:0] amt;
        logic [7:0] q;
        logic       busy, done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic rst, en, input logic [1:0] mode,
                               input logic sens, sr, sl, input logic [7:0] d,
                               input logic start, input logic [3:0] amt,
                               input logic [7:0] q, input logic busy, done);
        vec_t r;
        r.rst = rst; r.en = en; r.mode = mode; r.sens = sens; r.sr = sr; r.sl = sl;
        r.d = d; r.start = start; r.amt = amt; r.q = q; r.busy = busy; r.done = done;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        @(negedge H);
        RST = x.rst; EN = x.en; MODE = x.mode; SENS = x.sens; SR = x.sr; SL = x.sl;
        D = x.d; START = x.start; AMOUNT = x.amt;
    endtask

    // Loads a seed, requests a burst and counts edges until DONE appears.
    task automatic run_burst(input int id, input logic [7:0] seed, input logic [1:0] mode,
                             input logic sens, input logic serial, input logic [3:0] amt,
                             input logic [7:0] exp_q, input int exp_steps);
        int n;
        int busy_low;
        drive(v(0, 1, 2'b11, 0, 0, 0, seed, 0, 0, 0, 0, 0));
        drive(v(0, 1, mode, sens, serial, serial, 8'h00, 1, amt, 0, 0, 0));
        @(posedge H); #1;
        check("burst_accept_busy", id, BUSY, 1);
        drive(v(0, 1, 2'b11, ~sens, serial, serial, 8'h5A, 1, 4'd1, 0, 0, 0));
        n = 0;
        busy_low = 0;
        while (!DONE && n < 40) begin
            @(posedge H); #1;
            n++;
            if (!DONE && !BUSY) busy_low++;
        end
        check("burst_steps", id, n, exp_steps);
        check("burst_busy_held", id, busy_low, 0);
        check("burst_q", id, Q, exp_q);
        drive(v(0, 1, 2'b00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));
        @(posedge H); #1;
        check("burst_done_single", id, DONE, 0);
        $display("burst %0d: seed=%02h mode=%0d sens=%0d amt=%0d -> q=%02h steps=%0d", id, seed, mode, sens, amt, Q, n);
    endtask

    initial begin
        RST = 1; EN = 0; MODE = 0; SENS = 0; SR = 0; SL = 0; D = 0; START = 0; AMOUNT = 0;
        @(posedge H); #1;

        //           rst en mode  sens sr sl d      st amt    q      busy done
        vecs.push_back(v(0, 1, 2'b11, 0, 0, 0, 8'hA5, 0, 4'd0, 8'hA5, 0, 0));
        vecs.push_back(v(1, 0, 2'b11, 0, 0, 0, 8'h11, 1, 4'd3, 8'h00, 0, 0));
        vecs.push_back(v(0, 1, 2'b11, 0, 0, 0, 8'h96, 0, 4'd0, 8'h96, 0, 0));
        vecs.push_back(v(0, 1, 2'b01, 0, 1, 0, 8'h00, 0, 4'd0, 8'hCB, 0, 0));
        vecs.push_back(v(0, 1, 2'b01, 1, 1, 0, 8'h00, 0, 4'd0, 8'h96, 0, 0));
        vecs.push_back(v(0, 1, 2'b00, 0, 1, 1, 8'hFF, 0, 4'd0, 8'h96, 0, 0));
        vecs.push_back(v(0, 0, 2'b11, 0, 0, 0, 8'hFF, 1, 4'd2, 8'h96, 0, 0));
        // rotate-left burst of 3 from 0x81; live MODE/D/START ignored while running
        vecs.push_back(v(0, 1, 2'b11, 0, 0, 0, 8'h81, 0, 4'd0, 8'h81, 0, 0));
        vecs.push_back(v(0, 1, 2'b10, 1, 0, 0, 8'h00, 1, 4'd3, 8'h81, 1, 0));
        vecs.push_back(v(0, 1, 2'b11, 0, 1, 1, 8'hFF, 1, 4'd7, 8'h03, 1, 0));
        vecs.push_back(v(0, 1, 2'b11, 0, 1, 1, 8'hFF, 0, 4'd0, 8'h06, 1, 0));
        vecs.push_back(v(0, 1, 2'b11, 0, 1, 1, 8'hFF, 0, 4'd0, 8'h0C, 0, 1));
        vecs.push_back(v(0, 0, 2'b00, 0, 0, 0, 8'h00, 0, 4'd0, 8'h0C, 0, 0));
        // same burst with two stall cycles
        vecs.push_back(v(0, 1, 2'b11, 0, 0, 0, 8'h81, 0, 4'd0, 8'h81, 0, 0));
        vecs.push_back(v(0, 1, 2'b10, 1, 0, 0, 8'h00, 1, 4'd3, 8'h81, 1, 0));
        vecs.push_back(v(0, 1, 2'b00, 0, 0, 0, 8'h00, 0, 4'd0, 8'h03, 1, 0));
        vecs.push_back(v(0, 0, 2'b00, 0, 0, 0, 8'h00, 0, 4'd0, 8'h03, 1, 0));
        vecs.push_back(v(0, 0, 2'b00, 0, 0, 0, 8'h00, 0, 4'd0, 8'h03, 1, 0));
        vecs.push_back(v(0, 1, 2'b00, 0, 0, 0, 8'h00, 0, 4'd0, 8'h06, 1, 0));
        vecs.push_back(v(0, 1, 2'b00, 0, 0, 0, 8'h00, 0, 4'd0, 8'h0C, 0, 1));
        vecs.push_back(v(0, 1, 2'b00, 0, 0, 0, 8'h00, 0, 4'd0, 8'h0C, 0, 0));
        // abort after one step
        vecs.push_back(v(0, 1, 2'b10, 1, 0, 0, 8'h00, 1, 4'd3, 8'h0C, 1, 0));
        vecs.push_back(v(0, 1, 2'b00, 0, 0, 0, 8'h00, 0, 4'd0, 8'h18, 1, 0));
        vecs.push_back(v(1, 1, 2'b00, 0, 0, 0, 8'h00, 0, 4'd0, 8'h00, 0, 0));
        vecs.push_back(v(0, 1, 2'b00, 0, 0, 0, 8'h00, 0, 4'd0, 8'h00, 0, 0));
        vecs.push_back(v(0, 1, 2'b00, 0, 0, 0, 8'h00, 0, 4'd0, 8'h00, 0, 0));
        vecs.push_back(v(0, 1, 2'b00, 0, 0, 0, 8'h00, 0, 4'd0, 8'h00, 0, 0));
        // zero-length burst and START with load mode
        vecs.push_back(v(0, 1, 2'b11, 0, 0, 0, 8'h5A, 0, 4'd0, 8'h5A, 0, 0));
        vecs.push_back(v(0, 1, 2'b01, 0, 1, 1, 8'h00, 1, 4'd0, 8'h5A, 0, 1));
        vecs.push_back(v(0, 1, 2'b00, 0, 0, 0, 8'h00, 0, 4'd0, 8'h5A, 0, 0));
        vecs.push_back(v(0, 1, 2'b11, 0, 0, 0, 8'h3C, 1, 4'd5, 8'h3C, 0, 0));
        vecs.push_back(v(0, 1, 2'b10, 0, 1, 1, 8'h00, 0, 4'd0, 8'h1E, 0, 0));
        // one-step left shift, then a new burst accepted while DONE is high
        vecs.push_back(v(0, 1, 2'b01, 1, 0, 1, 8'h00, 1, 4'd1, 8'h1E, 1, 0));
        vecs.push_back(v(0, 1, 2'b00, 0, 0, 1, 8'h00, 0, 4'd0, 8'h3D, 0, 1));
        vecs.push_back(v(0, 1, 2'b10, 0, 0, 0, 8'h00, 1, 4'd2, 8'h3D, 1, 0));
        vecs.push_back(v(0, 1, 2'b00, 0, 0, 0, 8'h00, 0, 4'd0, 8'h9E, 1, 0));
        vecs.push_back(v(0, 1, 2'b00, 0, 0, 0, 8'h00, 0, 4'd0, 8'h4F, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge H); #1;
            check("q", i, Q, vecs[i].q);
            check("busy", i, BUSY, vecs[i].busy);
            check("done", i, DONE, vecs[i].done);
            check("so_r", i, SO_R, vecs[i].q[0]);
            check("so_l", i, SO_L, vecs[i].q[7]);
            $display("vec %0d: rst=%0d en=%0d mode=%0d st=%0d -> q=%02h busy=%0d done=%0d", i,
                     vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].start, Q, BUSY, DONE);
        end

        run_burst(0, 8'hFF, 2'b01, 1'b0, 1'b0, 4'd10, 8'h00, 10);
        run_burst(1, 8'h81, 2'b10, 1'b1, 1'b0, 4'd9,  8'h03, 9);
        run_burst(2, 8'hA5, 2'b10, 1'b0, 1'b1, 4'd8,  8'hA5, 8);
        run_burst(3, 8'h00, 2'b01, 1'b1, 1'b1, 4'd15, 8'hFF, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
